dither_ctrl: RTL
================

Name: dither_ctrl

Overview:
- Sequences the LFSR dither generator feeding the delta-sigma modulator: reset, warm-up, per-sample stepping, amplitude control and mute.
- Drives the generator's reset and step-enable, takes its registered T_BITS dither word, attenuates it by an arithmetic right shift, and answers each modulator sample request with exactly one dither word.
- Ramps the amplitude in and out so that enabling or disabling dither never produces a step.

Parameters:
- DW, `T_BITS, width of the dither word in and out.
- WARMUP, 64, generator steps discarded after generator reset before dither is used (0 = no warm-up).
- SHIFT_W, 3, width of the attenuation shift; MAX_SH = 2^SHIFT_W - 1.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- en_i  in  1  dither enable (level).
- amp_i  in  SHIFT_W  target attenuation (right-shift count); sampled on cfg_we_i.
- cfg_we_i  in  1  one-cycle strobe that latches amp_i into the target shift.
- req_i  in  1  modulator sample request (one-cycle pulse).
- dith_i  in  DW  signed dither word from the generator.
- gen_reset_o  out  1  holds the generator in reset.
- gen_step_o  out  1  advances the generator one step.
- dith_o  out  DW  signed attenuated dither word.
- dith_valid_o  out  1  dith_o is valid this cycle.
- busy_o  out  1  high in INIT, WARM and RAMP_DN.
- state_o  out  3  current state encoding (debug).

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: state IDLE, gen_reset_o=1, gen_step_o=0, dith_o=0, dith_valid_o=0, busy_o=0, target shift = MAX_SH, current shift cur_sh = MAX_SH, warm-up counter = 0. Reset asserted mid-operation returns to exactly these values in the same cycle.
- States: IDLE=0, INIT=1, WARM=2, RUN=3, RAMP_DN=4.
- IDLE:
  - gen_reset_o=1, cur_sh=MAX_SH.
  - en_i=1 -> INIT.
- INIT:
  - gen_reset_o=1 for exactly 2 cycles, then -> WARM (WARMUP>0) or -> RUN (WARMUP=0).
  - en_i=0 -> IDLE.
- WARM:
  - gen_reset_o=0, gen_step_o=1 every cycle.
  - The counter counts steps; after exactly WARMUP steps -> RUN.
  - en_i=0 -> IDLE.
- RUN:
  - gen_step_o = req_i (combinational, same cycle).
  - On each req_i, cur_sh moves one step toward the target (decrement if greater, increment if smaller, hold if equal). The new value is used for that request.
  - en_i=0 -> RAMP_DN.
- RAMP_DN:
  - gen_step_o = req_i. Each req_i increments cur_sh by 1.
  - A req_i arriving with cur_sh already at MAX_SH is answered with 0 and the state goes -> IDLE.
  - en_i=1 during RAMP_DN -> RUN without re-init; the ramp continues toward the target.
- Request response, every state:
  - req_i in cycle n -> dith_valid_o=1 for one cycle at n+1.
  - In RUN or RAMP_DN: dith_o = dith_i sampled at n, arithmetically right-shifted (sign-extended) by the updated cur_sh.
  - In IDLE, INIT or WARM: dith_o=0.
  - dith_o holds its value while dith_valid_o=0.
  - Back-to-back req_i on consecutive cycles is legal and is answered every cycle.
- cfg_we_i: latches amp_i into the target in any state and never alters cur_sh directly. When cfg_we_i and req_i coincide, the step uses the newly latched target.
- WARM and req_i coinciding: generator stepping is unchanged (already stepping every cycle); the reply is 0.
- busy_o and state_o are registered and reflect the current state.

Decomposition:
- parameters.vh gains: state encodings (DC_IDLE..DC_RAMP_DN), DC_INIT_CYC=2, default WARMUP.
- One natural sub-module: dither_shift, a combinational signed arithmetic right shifter of DW bits by SHIFT_W bits, reused by later gain stages.
- The FSM, counters and output register stay in dither_ctrl.

Test Plan:
- Reset, then en_i=1 with WARMUP=64 -> gen_reset_o high for exactly 2 cycles, gen_step_o high for exactly 64 cycles, state_o=3 on the next cycle; busy_o high throughout INIT and WARM.
- RUN, target=2, cur_sh=2, dith_i=16'hF000, req_i pulse -> next cycle dith_valid_o=1, dith_o=16'hFC00; gen_step_o high only in the req cycle.
- Ramp-in from MAX_SH=7 with target 2 and dith_i=16'h4000 held -> successive replies 16'h0100, 16'h0200, 16'h0400, 16'h0800, 16'h1000, then steady at 16'h1000.
- en_i=0 in RUN with cur_sh=5 and dith_i=16'h4000 -> replies 16'h0100, 16'h0080, then 0 with state_o=0 and gen_reset_o=1.
- req_i during WARM and in IDLE -> dith_valid_o pulses with dith_o=0; warm-up step count still exactly 64.
- Reset asserted asynchronously mid-RUN between clock edges -> all outputs at their reset values immediately; en_i held at 1 -> INIT sequence restarts after release.

Source files
------------

// File: rtl/dither_ctrl_pkg.sv
// Shared types and constants for the dither sequencer.
// State encodings, init length and default warm-up depth.
package dither_ctrl_pkg;

   localparam int T_BITS        = 16;
   localparam int DC_INIT_CYC   = 2;
   localparam int DC_WARMUP_DEF = 64;

   typedef enum logic [2:0] {
      DC_IDLE    = 3'd0,
      DC_INIT    = 3'd1,
      DC_WARM    = 3'd2,
      DC_RUN     = 3'd3,
      DC_RAMP_DN = 3'd4
   } dc_state_e;

   function automatic logic dc_busy(dc_state_e s);
      return (s == DC_INIT) || (s == DC_WARM) || (s == DC_RAMP_DN);
   endfunction

endpackage

// File: rtl/dither_if.sv
// Modulator-side request/reply bundle of the dither sequencer.
// The modulator is master; dither_ctrl answers as slave.
interface dither_if
   import dither_ctrl_pkg::*;
#(
   parameter int DW = T_BITS
) ();

   logic          req_i;
   logic [DW-1:0] dith_o;
   logic          dith_valid_o;

   modport master (
      output req_i,
      input  dith_o,
      input  dith_valid_o
   );

   modport slave (
      input  req_i,
      output dith_o,
      output dith_valid_o
   );

endinterface

// File: rtl/dither_shift.sv
// Combinational signed arithmetic right shifter.
// Sign bit fills the vacated MSBs.
module dither_shift #(
   parameter int DW      = 16,
   parameter int SHIFT_W = 3
) (
   input  logic [DW-1:0]      din,
   input  logic [SHIFT_W-1:0] sh,
   output logic [DW-1:0]      dout
);

   assign dout = $signed(din) >>> sh;

endmodule

// File: rtl/dither_ctrl.sv
// Sequencer for the LFSR dither generator: reset, warm-up,
// per-request stepping, amplitude ramping and mute.
module dither_ctrl
   import dither_ctrl_pkg::*;
#(
   parameter int DW      = T_BITS,
   parameter int WARMUP  = DC_WARMUP_DEF,
   parameter int SHIFT_W = 3
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               en_i,
   input  logic [SHIFT_W-1:0] amp_i,
   input  logic               cfg_we_i,
   input  logic [DW-1:0]      dith_i,
   dither_if.slave            mod,
   output logic               gen_reset_o,
   output logic               gen_step_o,
   output logic               busy_o,
   output logic [2:0]         state_o
);

   localparam int CW = (WARMUP > 3) ? $clog2(WARMUP + 1) : 2;
   localparam logic [SHIFT_W-1:0] MAX_SH = {SHIFT_W{1'b1}};
   localparam logic [CW-1:0] INIT_LAST = CW'(DC_INIT_CYC - 1);
   localparam logic [CW-1:0] WARM_LAST =
      CW'((WARMUP > 0) ? WARMUP - 1 : 0);

   dc_state_e          state_q;
   dc_state_e          state_n;
   logic [CW-1:0]      cnt_q;
   logic [CW-1:0]      cnt_n;
   logic [SHIFT_W-1:0] sh_q;
   logic [SHIFT_W-1:0] sh_n;
   logic [SHIFT_W-1:0] tgt_q;
   logic [SHIFT_W-1:0] tgt_eff;
   logic [SHIFT_W-1:0] sh_toward;
   logic [DW-1:0]      dith_q;
   logic [DW-1:0]      shifted;
   logic [DW-1:0]      reply;
   logic               valid_q;
   logic               busy_q;
   logic               reply_on;
   logic               gen_rst;
   logic               gen_step;

   // A coincident config write takes effect for this request's step.
   assign tgt_eff = cfg_we_i ? amp_i : tgt_q;

   always_comb begin
      sh_toward = sh_q;
      if (sh_q > tgt_eff) begin
         sh_toward = sh_q - SHIFT_W'(1);
      end else if (sh_q < tgt_eff) begin
         sh_toward = sh_q + SHIFT_W'(1);
      end
   end

   always_comb begin
      state_n  = state_q;
      cnt_n    = cnt_q;
      sh_n     = sh_q;
      gen_rst  = 1'b0;
      gen_step = 1'b0;
      reply_on = 1'b0;
      unique case (state_q)
         DC_IDLE: begin
            gen_rst = 1'b1;
            sh_n    = MAX_SH;
            cnt_n   = '0;
            if (en_i) begin
               state_n = DC_INIT;
            end
         end
         DC_INIT: begin
            gen_rst = 1'b1;
            if (!en_i) begin
               state_n = DC_IDLE;
               cnt_n   = '0;
            end else if (cnt_q == INIT_LAST) begin
               cnt_n   = '0;
               state_n = (WARMUP > 0) ? DC_WARM : DC_RUN;
            end else begin
               cnt_n = cnt_q + CW'(1);
            end
         end
         DC_WARM: begin
            gen_step = 1'b1;
            if (!en_i) begin
               state_n = DC_IDLE;
               cnt_n   = '0;
            end else if (cnt_q == WARM_LAST) begin
               cnt_n   = '0;
               state_n = DC_RUN;
            end else begin
               cnt_n = cnt_q + CW'(1);
            end
         end
         DC_RUN: begin
            gen_step = mod.req_i;
            if (mod.req_i) begin
               sh_n     = sh_toward;
               reply_on = 1'b1;
            end
            if (!en_i) begin
               state_n = DC_RAMP_DN;
            end
         end
         DC_RAMP_DN: begin
            gen_step = mod.req_i;
            // Re-enable resumes the ramp toward target without re-init.
            if (en_i) begin
               state_n = DC_RUN;
               if (mod.req_i) begin
                  sh_n     = sh_toward;
                  reply_on = 1'b1;
               end
            end else if (mod.req_i) begin
               if (sh_q == MAX_SH) begin
                  state_n = DC_IDLE;
               end else begin
                  sh_n     = sh_q + SHIFT_W'(1);
                  reply_on = 1'b1;
               end
            end
         end
         default: begin
            state_n = DC_IDLE;
         end
      endcase
   end

   dither_shift #(
      .DW      (DW),
      .SHIFT_W (SHIFT_W)
   ) u_shift (
      .din  (dith_i),
      .sh   (sh_n),
      .dout (shifted)
   );

   assign reply = reply_on ? shifted : '0;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= DC_IDLE;
         cnt_q   <= '0;
         sh_q    <= MAX_SH;
         tgt_q   <= MAX_SH;
         dith_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_n;
         cnt_q   <= cnt_n;
         sh_q    <= sh_n;
         valid_q <= mod.req_i;
         busy_q  <= dc_busy(state_n);
         if (cfg_we_i) begin
            tgt_q <= amp_i;
         end
         if (mod.req_i) begin
            dith_q <= reply;
         end
      end
   end

   assign gen_reset_o      = gen_rst;
   assign gen_step_o       = gen_step;
   assign busy_o           = busy_q;
   assign state_o          = state_q;
   assign mod.dith_o       = dith_q;
   assign mod.dith_valid_o = valid_q;

endmodule
